// File: rtl/ultrasonic_ranger.sv
// rtl/ultrasonic_ranger.sv - round-robin multi-channel ultrasonic echo-width ranging controller
module ultrasonic_ranger #(
    parameter int N_CH       = 4,
    parameter int TRIG_CYC   = 1500,
    parameter int PERIOD_CYC = 8750000,
    parameter int MEAS_W     = 24,
    parameter int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N_CH-1:0]   echo,
    output logic [N_CH-1:0]   trig,
    output logic              busy,
    output logic              meas_valid,
    output logic [CH_W-1:0]   meas_ch,
    output logic [MEAS_W-1:0] meas_cycles,
    output logic              meas_timeout
);

    localparam int SLOT_W = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam int N_PAD  = 2 ** CH_W;

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(PERIOD_CYC - 1);
    localparam logic [SLOT_W-1:0] TRIG_LAST = SLOT_W'(TRIG_CYC - 1);
    localparam logic [MEAS_W-1:0] MEAS_MAX  = '1;
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(N_CH - 1);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        HOLDOFF
    } state_t;

    state_t              state;
    state_t              state_next;
    state_t              slot_exit;
    logic [N_CH-1:0]     echo_m;
    logic [N_CH-1:0]     echo_s;
    logic [N_CH-1:0]     echo_d;
    logic [N_PAD-1:0]    sel_s;
    logic [N_PAD-1:0]    sel_d;
    logic [SLOT_W-1:0]   slot_cnt;
    logic [MEAS_W-1:0]   meas_cnt;
    logic [CH_W-1:0]     ch;
    logic                rise;
    logic                fall;
    logic                slot_end;
    logic                in_window;
    logic                result_now;
    logic                slot_start;

    // Padding lets the channel index address the echo vector for any N_CH.
    assign sel_s      = N_PAD'(echo_s);
    assign sel_d      = N_PAD'(echo_d);
    assign rise       = sel_s[ch] & ~sel_d[ch];
    assign fall       = ~sel_s[ch] & sel_d[ch];
    assign slot_end   = (slot_cnt == SLOT_LAST);
    assign in_window  = (state == WAIT_RISE) || (state == MEASURE);
    // A fall on the very last slot cycle still counts as a complete echo.
    assign result_now = ((state == MEASURE) && fall) || (in_window && slot_end);
    assign slot_start = (state_next == TRIG) && (state != TRIG);
    assign slot_exit  = en ? TRIG : IDLE;

    // Two-flop synchroniser plus one delayed copy for edge detection, all channels.
    always_ff @(posedge clk) begin
        if (rst) begin
            echo_m <= '0;
            echo_s <= '0;
            echo_d <= '0;
        end else begin
            echo_m <= echo;
            echo_s <= echo_m;
            echo_d <= echo_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // FSM next-state logic; every slot ends on the same slot count so triggers stay periodic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (en) state_next = TRIG;
            TRIG:      if (slot_cnt == TRIG_LAST) state_next = WAIT_RISE;
            WAIT_RISE: begin
                if (slot_end)  state_next = slot_exit;
                else if (rise) state_next = MEASURE;
            end
            MEASURE: begin
                if (slot_end)  state_next = slot_exit;
                else if (fall) state_next = HOLDOFF;
            end
            HOLDOFF:   if (slot_end) state_next = slot_exit;
            default:   state_next = IDLE;
        endcase
    end

    // FSM outputs: trigger pin of the active channel, busy flag.
    always_comb begin
        trig = '0;
        busy = (state != IDLE);
        if (state == TRIG) trig = N_CH'(1) << ch;
    end

    // Slot/measurement counters, channel rotation and the registered result strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt     <= '0;
            meas_cnt     <= '0;
            ch           <= '0;
            meas_valid   <= 1'b0;
            meas_ch      <= '0;
            meas_cycles  <= '0;
            meas_timeout <= 1'b0;
        end else begin
            meas_valid <= 1'b0;

            if (slot_start || (state_next == IDLE)) slot_cnt <= '0;
            else                                    slot_cnt <= slot_cnt + 1'b1;

            if (state == TRIG) begin
                meas_cnt <= '0;
            end else if ((state == WAIT_RISE) && rise) begin
                meas_cnt <= MEAS_W'(1);
            end else if ((state == MEASURE) && sel_s[ch] && (meas_cnt != MEAS_MAX)) begin
                meas_cnt <= meas_cnt + 1'b1;
            end

            if (result_now) begin
                meas_valid   <= 1'b1;
                meas_ch      <= ch;
                meas_cycles  <= meas_cnt;
                meas_timeout <= !((state == MEASURE) && fall);
            end

            if (busy && (state != TRIG) && slot_end) begin
                ch <= (ch == CH_LAST) ? '0 : ch + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// tb/tb_ultrasonic_ranger.sv - scoreboard bench for ultrasonic_ranger with randomized echo pulses
module tb_ultrasonic_ranger;

    localparam int N_CH  = 2;
    localparam int T     = 10;
    localparam int P     = 200;
    localparam int MW    = 6;
    localparam int MAXC  = (1 << MW) - 1;
    localparam int NS    = 40;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [1:0]    echo;
    logic [1:0]    trig;
    logic          busy;
    logic          meas_valid;
    logic [0:0]    meas_ch;
    logic [MW-1:0] meas_cycles;
    logic          meas_timeout;

    ultrasonic_ranger #(
        .N_CH(N_CH), .TRIG_CYC(T), .PERIOD_CYC(P), .MEAS_W(MW)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .echo(echo), .trig(trig), .busy(busy),
        .meas_valid(meas_valid), .meas_ch(meas_ch), .meas_cycles(meas_cycles),
        .meas_timeout(meas_timeout)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int ch;
        int cycles;
        int to;
        int at;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, edge_n);
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, int'({trig, busy, meas_valid, meas_ch, meas_cycles, meas_timeout}), 0);
    endtask

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Reference model: what one slot must report, from trigger rise E and raw echo pulse [A, A+W).
    task automatic model_push(input int E, input int ch, input int A, input int W);
        exp_t e;
        int   weff;
        int   rise_c;
        int   fall_c;
        weff = (A >= E + P) ? 0 : min_i(W, E + P - A);
        rise_c = A + 2;
        e.ch = ch;
        if (weff > 0 && rise_c >= E + T && rise_c <= E + P - 2) begin
            fall_c = A + weff + 2;
            if (fall_c <= E + P - 1) begin
                e.cycles = min_i(weff, MAXC);
                e.to     = 0;
                e.at     = fall_c + 1;
            end else begin
                e.cycles = min_i(E + P - A - 3, MAXC);
                e.to     = 1;
                e.at     = E + P;
            end
        end else begin
            e.cycles = 0;
            e.to     = 1;
            e.at     = E + P;
        end
        expq.push_back(e);
    endtask

    // Monitor: every strobe is matched against the oldest expected result.
    always @(negedge clk) begin
        if (meas_valid === 1'b1) begin
            if (expq.size() == 0) begin
                check("unexpected_strobe", 1, 0);
            end else begin
                mon_e = expq.pop_front();
                check("meas_ch", int'(meas_ch), mon_e.ch);
                check("meas_cycles", int'(meas_cycles), mon_e.cycles);
                check("meas_timeout", int'(meas_timeout), mon_e.to);
                check("strobe_cycle", edge_n, mon_e.at);
            end
        end
    end

    // Drives one slot from cycle E-1 through E+P-1; optionally drops en or pulses rst.
    task automatic do_slot(input int E, input int ch, input int A, input int W,
                           input int drop_at, input int rst_at, output int abort_n);
        int         trig_bad;
        int         busy_bad;
        logic [1:0] exp_trig;
        abort_n  = -1;
        trig_bad = 0;
        busy_bad = 0;
        if (rst_at < 0) model_push(E, ch, A, W);
        for (int n = E - 1; n <= E + P - 1; n++) begin
            if (n > E - 1) begin
                @(posedge clk);
                #1;
            end
            for (int k = 0; k < N_CH; k++) begin
                if (k == ch) echo[k] = (n >= A) && (n < A + W) && (n < E + P);
                else         echo[k] = (n < E + P - 10) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            if (n == drop_at) en = 1'b0;
            if (n >= E) begin
                exp_trig = (n < E + T) ? (2'(1) << ch) : 2'b00;
                if (trig !== exp_trig) trig_bad++;
                if (busy !== 1'b1) busy_bad++;
            end
            if (n == rst_at) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst  = 1'b0;
                echo = 2'b00;
                check_all_zero("reset_mid_slot");
                abort_n = n + 1;
                break;
            end
        end
        check("trig_pattern_bad_cycles", trig_bad, 0);
        check("busy_in_slot_bad_cycles", busy_bad, 0);
    endtask

    initial begin
        int E;
        int ch;
        int A;
        int W;
        int drop_at;
        int rst_at;
        int abort_n;
        int kind;
        int idle_bad;

        rst  = 1'b1;
        en   = 1'b1;
        echo = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_all_zero("reset_hold_outputs");
        end
        rst  = 1'b0;
        echo = 2'b00;
        ch   = 0;
        E    = edge_n + 1;

        for (int s = 0; s < NS; s++) begin
            drop_at = -1;
            rst_at  = -1;
            case (s)
                0: begin A = E + T + 20; W = 50;    end
                1: begin A = E + P;      W = 1;     end
                2: begin A = E - 1;      W = P + 10; end
                3: begin A = E + T + 5;  W = P;     end
                4: begin A = E + T + 5;  W = 40; drop_at = E + 30; end
                5: begin A = E + T + 5;  W = 100; rst_at = E + T + 25; end
                default: begin
                    kind = int'($urandom_range(0, 3));
                    case (kind)
                        0:       begin A = E + T - 2 + int'($urandom_range(0, 60)); W = int'($urandom_range(1, 120)); end
                        1:       begin A = E + P; W = 1; end
                        2:       begin A = E - 1 + int'($urandom_range(0, T - 3)); W = P + 10; end
                        default: begin A = E - 1 + int'($urandom_range(0, P)); W = int'($urandom_range(1, P)); end
                    endcase
                    if ($urandom_range(0, 7) == 0) drop_at = E + int'($urandom_range(T, P - 2));
                end
            endcase

            do_slot(E, ch, A, W, drop_at, rst_at, abort_n);

            if (abort_n >= 0) begin
                ch = 0;
                E  = edge_n + 1;
                continue;
            end

            ch = (ch + 1) % N_CH;
            if (en == 1'b0) begin
                idle_bad = 0;
                for (int i = 0; i < 12; i++) begin
                    @(posedge clk);
                    #1;
                    echo = 2'b00;
                    if (trig !== 2'b00 || busy !== 1'b0) idle_bad++;
                end
                check("idle_quiet_bad_cycles", idle_bad, 0);
                en = 1'b1;
            end
            E = edge_n + 1;
        end

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        check("results_outstanding", expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
